// File: rtl/conv_pkg.sv
// Shared encodings for the convolution job scheduler: FSM state codes and
// the loader stream select values seen on ld_sel.
package conv_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_IM2COL = 3'd1;
    localparam logic [2:0] ST_LOAD_W = 3'd2;
    localparam logic [2:0] ST_LOAD_X = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam logic LD_SEL_W = 1'b0;
    localparam logic LD_SEL_X = 1'b1;

endpackage

// File: rtl/conv_sched_loader.sv
// Streams count words from base: issues one read per cycle and presents each
// word on the ld_* channel the cycle after its read was issued.
module conv_sched_loader #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [31:0]           count_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  ld_valid_o,
    output logic [31:0]           ld_idx_o,
    output logic                  last_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // cnt_q runs 0..count_i: step c issues read c and returns word c-1
    always_comb begin
        last_o     = en_i && (cnt_q == count_i);
        cnt_d      = (en_i && !last_o) ? cnt_q + 32'd1 : '0;
        rd_addr_o  = '0;
        ld_valid_o = 1'b0;
        ld_idx_o   = '0;
        if (en_i && (cnt_q < count_i)) begin
            rd_addr_o = base_i + ADDR_WIDTH'(cnt_q);
        end
        if (en_i && (cnt_q != '0)) begin
            ld_valid_o = 1'b1;
            ld_idx_o   = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_sched.sv
// Convolution job scheduler: im2col, weight/X load, systolic run, write-back.
// Optional CONV_SCHED_PERF_EN adds the perf_cycles job-length counter.
module conv_sched
    import conv_pkg::*;
#(
    parameter int unsigned M           = 12,
    parameter int unsigned N           = 9,
    parameter int unsigned K           = 5,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned WEIGHT_BASE = 32'h1000,
    parameter int unsigned IM2COL_BASE = 32'h2000,
    parameter int unsigned OUTPUT_BASE = 32'h3000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    im2col_rst,
    input  logic                    im2col_done,
    input  logic [ADDR_WIDTH-1:0]   im2col_addr_rd,
    input  logic [ADDR_WIDTH-1:0]   im2col_addr_wr,
    input  logic                    im2col_wr_en,
    input  logic [DATA_WIDTH-1:0]   im2col_data_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr_rd,
    output logic [ADDR_WIDTH-1:0]   mem_addr_wr,
    output logic                    mem_wr_en,
    output logic [DATA_WIDTH-1:0]   mem_data_wr,
    input  logic [DATA_WIDTH-1:0]   mem_data_rd,
    output logic                    ld_valid,
    output logic                    ld_sel,
    output logic [31:0]             ld_idx,
    output logic [DATA_WIDTH-1:0]   ld_data,
    output logic                    sa_rst,
    input  logic                    sa_valid,
    input  logic [K*DATA_WIDTH-1:0] sa_y,
    input  logic                    sa_done
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_cycles
`endif
);

    localparam int unsigned YW = $clog2(M + 1);
    localparam int unsigned FW = $clog2(K + 1);
    localparam int unsigned WW = $clog2(K * M + 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(M);
    localparam logic [YW-1:0] P_LAST  = YW'(M - 1);
    localparam logic [WW-1:0] WB_LAST = WW'(K * M - 1);

    logic [STATE_W-1:0]      state_q, state_d;
    logic [YW-1:0]           y_cnt_q, y_cnt_d;
    logic [YW-1:0]           p_q, p_d;
    logic [FW-1:0]           f_q, f_d;
    logic [WW-1:0]           wb_q, wb_d;
    logic [K*DATA_WIDTH-1:0] ybuf_q [M];

    logic                    job_start;
    logic                    ybuf_we;
    logic [DATA_WIDTH-1:0]   wb_data;

    logic                    ldr_en;
    logic [ADDR_WIDTH-1:0]   ldr_base;
    logic [31:0]             ldr_count;
    logic [ADDR_WIDTH-1:0]   ldr_addr;
    logic                    ldr_last;

    assign job_start = (state_q == ST_IDLE) && start;
    assign ldr_en    = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
    assign ldr_base  = (state_q == ST_LOAD_X) ? ADDR_WIDTH'(IM2COL_BASE) : ADDR_WIDTH'(WEIGHT_BASE);
    assign ldr_count = (state_q == ST_LOAD_X) ? 32'(M * N) : 32'(N * K);

    conv_sched_loader #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_loader (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (ldr_en),
        .base_i     (ldr_base),
        .count_i    (ldr_count),
        .rd_addr_o  (ldr_addr),
        .ld_valid_o (ld_valid),
        .ld_idx_o   (ld_idx),
        .last_o     (ldr_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)       state_d = ST_IM2COL;
            ST_IM2COL: if (im2col_done) state_d = ST_LOAD_W;
            ST_LOAD_W: if (ldr_last)    state_d = ST_LOAD_X;
            ST_LOAD_X: if (ldr_last)    state_d = ST_RUN;
            ST_RUN:    if (sa_done)     state_d = ST_WB;
            ST_WB:     if (wb_q == WB_LAST) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        y_cnt_d = y_cnt_q;
        ybuf_we = 1'b0;
        if (job_start) begin
            y_cnt_d = '0;
        end else if ((state_q == ST_RUN) && sa_valid && (y_cnt_q < Y_MAX)) begin
            y_cnt_d = y_cnt_q + YW'(1);
            ybuf_we = 1'b1;
        end
    end

    // f outer, p inner; wb_q tracks f*M+p directly so no multiply is needed
    always_comb begin
        p_d  = '0;
        f_d  = '0;
        wb_d = '0;
        if ((state_q == ST_WB) && (wb_q != WB_LAST)) begin
            wb_d = wb_q + WW'(1);
            if (p_q == P_LAST) begin
                f_d = f_q + FW'(1);
            end else begin
                p_d = p_q + YW'(1);
                f_d = f_q;
            end
        end
    end

    always_comb begin
        wb_data = '0;
        for (int unsigned f = 0; f < K; f++) begin
            if (f_q == FW'(f)) begin
                wb_data = ybuf_q[p_q][f*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        done        = (state_q == ST_DONE);
        im2col_rst  = (state_q != ST_IM2COL);
        sa_rst      = (state_q != ST_RUN);
        ld_sel      = (state_q == ST_LOAD_X) ? LD_SEL_X : LD_SEL_W;
        ld_data     = mem_data_rd;
        mem_addr_rd = '0;
        mem_addr_wr = '0;
        mem_wr_en   = 1'b0;
        mem_data_wr = '0;
        if (state_q == ST_IM2COL) begin
            mem_addr_rd = im2col_addr_rd;
            mem_addr_wr = im2col_addr_wr;
            mem_wr_en   = im2col_wr_en;
            mem_data_wr = im2col_data_wr;
        end else if (ldr_en) begin
            mem_addr_rd = ldr_addr;
        end else if (state_q == ST_WB) begin
            mem_addr_wr = ADDR_WIDTH'(OUTPUT_BASE) + ADDR_WIDTH'(wb_q);
            mem_wr_en   = 1'b1;
            mem_data_wr = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_cnt_q <= '0;
            p_q     <= '0;
            f_q     <= '0;
            wb_q    <= '0;
            for (int unsigned i = 0; i < M; i++) begin
                ybuf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            y_cnt_q <= y_cnt_d;
            p_q     <= p_d;
            f_q     <= f_d;
            wb_q    <= wb_d;
            if (job_start) begin
                for (int unsigned i = 0; i < M; i++) begin
                    ybuf_q[i] <= '0;
                end
            end else if (ybuf_we) begin
                ybuf_q[y_cnt_q] <= sa_y;
            end
        end
    end

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (job_start) begin
            perf_q <= '0;
        end else if ((state_q != ST_IDLE) && (state_q != ST_DONE)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: memory, im2col and systolic-array models
// around the scheduler, with output rows checked against hand-built values.
module tb_conv_sched;

    localparam int M  = 12;
    localparam int N  = 9;
    localparam int K  = 5;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, start, busy, done;
    logic            im2col_rst, im2col_done, im2col_wr_en;
    logic [AW-1:0]   im2col_addr_rd, im2col_addr_wr;
    logic [DW-1:0]   im2col_data_wr;
    logic [AW-1:0]   mem_addr_rd, mem_addr_wr;
    logic            mem_wr_en;
    logic [DW-1:0]   mem_data_wr, mem_data_rd;
    logic            ld_valid, ld_sel;
    logic [31:0]     ld_idx;
    logic [DW-1:0]   ld_data;
    logic            sa_rst, sa_valid, sa_done;
    logic [K*DW-1:0] sa_y;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]     perf_cycles;
`endif

    conv_sched #(
        .M(M), .N(N), .K(K), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .WEIGHT_BASE(32'h1000), .IM2COL_BASE(32'h2000), .OUTPUT_BASE(32'h3000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .im2col_rst(im2col_rst), .im2col_done(im2col_done),
        .im2col_addr_rd(im2col_addr_rd), .im2col_addr_wr(im2col_addr_wr),
        .im2col_wr_en(im2col_wr_en), .im2col_data_wr(im2col_data_wr),
        .mem_addr_rd(mem_addr_rd), .mem_addr_wr(mem_addr_wr), .mem_wr_en(mem_wr_en),
        .mem_data_wr(mem_data_wr), .mem_data_rd(mem_data_rd),
        .ld_valid(ld_valid), .ld_sel(ld_sel), .ld_idx(ld_idx), .ld_data(ld_data),
        .sa_rst(sa_rst), .sa_valid(sa_valid), .sa_y(sa_y), .sa_done(sa_done)
`ifdef CONV_SCHED_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    int errs = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Port activity is captured mid-cycle so the models never race the DUT edge
    logic [31:0] mem [0:16383];
    logic        s_we, s_irst;
    logic [13:0] s_wa, s_ra;
    logic [31:0] s_wd, s_wa_full;
    int wb_total = 0, stray = 0;
    int w_seen = 0, x_seen = 0, ld_bad = 0, pass_bad = 0, entries = 0, done_total = 0;
    logic prev_irst = 1'b1;

    always @(negedge clk) begin
        s_we      = mem_wr_en;
        s_wa      = mem_addr_wr[13:0];
        s_wa_full = mem_addr_wr;
        s_wd      = mem_data_wr;
        s_ra      = mem_addr_rd[13:0];
        s_irst    = im2col_rst;
        if (!im2col_rst && prev_irst) begin
            entries++;
            w_seen = 0;
            x_seen = 0;
        end
        prev_irst = im2col_rst;
        if (!im2col_rst && (mem_addr_rd !== im2col_addr_rd || mem_wr_en !== im2col_wr_en ||
            (im2col_wr_en && (mem_addr_wr !== im2col_addr_wr || mem_data_wr !== im2col_data_wr))))
            pass_bad++;
        if (ld_valid) begin
            if (ld_sel == 1'b0) begin
                if (x_seen != 0 || ld_idx != 32'(w_seen) || ld_data !== 32'hA000_0000 + ld_idx) ld_bad++;
                w_seen++;
            end else begin
                if (w_seen != N*K || ld_idx != 32'(x_seen) || ld_data !== 32'hB000_0000 + ld_idx) ld_bad++;
                x_seen++;
            end
        end
        if (done) done_total++;
    end

    always @(posedge clk) begin
        if (s_we) begin
            mem[s_wa] = s_wd;
            if (s_wa_full >= 32'h3000 && s_wa_full <= 32'h303B) wb_total++;
            else if (!(s_wa_full >= 32'h2000 && s_wa_full < 32'(32'h2000 + M*N))) stray++;
        end
        mem_data_rd <= mem[s_ra];
    end

    // im2col stand-in: writes the X matrix, then signals done after 200 cycles
    int icnt = 0;
    always @(posedge clk) begin
        if (s_irst) begin
            icnt           <= 0;
            im2col_done    <= 1'b0;
            im2col_wr_en   <= 1'b0;
            im2col_addr_wr <= '0;
            im2col_addr_rd <= '0;
            im2col_data_wr <= '0;
        end else begin
            icnt           <= icnt + 1;
            im2col_wr_en   <= (icnt < M*N);
            im2col_addr_wr <= 32'(32'h2000 + icnt);
            im2col_addr_rd <= 32'(32'h5000 + icnt);
            im2col_data_wr <= 32'(32'hB000_0000 + icnt);
            im2col_done    <= (icnt == 198);
        end
    end

    function automatic logic [K*DW-1:0] row_val(input int base, input int p);
        logic [K*DW-1:0] v;
        v = '0;
        for (int f = 0; f < K; f++) v[f*DW +: DW] = 32'(base + 16*f + p);
        return v;
    endfunction

    task automatic drive_sa(input int rows, input int base);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (!sa_rst) ok = 1'b1;
        end
        check_eq("sa_rst_release", 64'(ok), 64'd1);
        for (int p = 0; p < rows; p++) begin
            @(posedge clk); #1;
            sa_valid = 1'b1;
            sa_y     = row_val(base, p);
        end
        @(posedge clk); #1;
        sa_valid = 1'b0;
        sa_y     = '0;
        sa_done  = 1'b1;
        @(posedge clk); #1;
        sa_done  = 1'b0;
    endtask

    task automatic run_job(input int rows, input int base, input bit hold);
        int d0, e0, wb0, ex;
        bit seen;
        for (int i = 0; i < K*M; i++) mem[32'h3000 + i] = 32'hDEAD_BEEF;
        for (int i = 0; i < M*N; i++) mem[32'h2000 + i] = 32'h0;
        d0 = done_total; e0 = entries; wb0 = wb_total;
        @(posedge clk); #1 start = 1'b1;
        if (!hold) begin
            @(posedge clk); #1 start = 1'b0;
        end
        drive_sa(rows, base);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        if (hold) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check_eq("start_in_done_ignored", 64'(busy), 64'd0);
        end
        repeat (3) @(negedge clk);
        check_eq("done_pulses", 64'(done_total - d0), 64'd1);
        check_eq("im2col_entries", 64'(entries - e0), 64'd1);
        check_eq("ld_w_count", 64'(w_seen), 64'(N*K));
        check_eq("ld_x_count", 64'(x_seen), 64'(M*N));
        check_eq("ld_stream_errs", 64'(ld_bad), 64'd0);
        check_eq("im2col_passthru_errs", 64'(pass_bad), 64'd0);
        check_eq("stray_writes", 64'(stray), 64'd0);
        check_eq("wb_write_count", 64'(wb_total - wb0), 64'(K*M));
        check_eq("busy_idle", 64'(busy), 64'd0);
        for (int f = 0; f < K; f++) begin
            for (int p = 0; p < M; p++) begin
                ex = (p < rows) ? base + 16*f + p : 0;
                check_eq($sformatf("out_f%0d_p%0d", f, p), 64'(mem[32'h3000 + f*M + p]), 64'(ex));
            end
        end
    endtask

    initial begin
        int d0;
        bit ok;
        rst_n = 1'b0; start = 1'b0; sa_valid = 1'b0; sa_done = 1'b0; sa_y = '0;
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        for (int i = 0; i < N*K; i++) mem[32'h1000 + i] = 32'(32'hA000_0000 + i);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_ld_valid", 64'(ld_valid), 64'd0);
        check_eq("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check_eq("rst_im2col_rst", 64'(im2col_rst), 64'd1);
        check_eq("rst_sa_rst", 64'(sa_rst), 64'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", 64'(busy), 64'd0);

        run_job(12, 0, 1'b0);
        run_job(15, 'h40, 1'b0);
        run_job(5, 'h100, 1'b0);

        d0 = done_total;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (x_seen >= 10) ok = 1'b1;
        end
        check_eq("reach_load_x", 64'(ok), 64'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_ld_valid", 64'(ld_valid), 64'd0);
        check_eq("abort_sa_rst", 64'(sa_rst), 64'd1);
        check_eq("abort_im2col_rst", 64'(im2col_rst), 64'd1);
        check_eq("abort_mem_wr_en", 64'(mem_wr_en), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("abort_no_done", 64'(done_total - d0), 64'd0);
        check_eq("abort_stays_idle", 64'(busy), 64'd0);

        run_job(12, 'h200, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
